// File: rtl/cpu_run_ctrl_if.sv
// Handshake and instruction-memory bundle between the lab3 CPU bench/datapath
// (master) and the run controller (slave).
interface cpu_run_ctrl_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 9,
  parameter int CNT_W   = 16
);
  logic               start_i;
  logic [ADDR_W-1:0]  start_addr_i;
  logic [ADDR_W-1:0]  imem_addr_o;
  logic               imem_rd_o;
  logic [INSTR_W-1:0] imem_data_i;
  logic [INSTR_W-1:0] instr_o;
  logic               instr_valid_o;
  logic               stall_i;
  logic               branch_taken_i;
  logic [ADDR_W-1:0]  branch_target_i;
  logic               done_o;
  logic [CNT_W-1:0]   cycle_count_o;
  logic [CNT_W-1:0]   instr_count_o;

  modport master (
    output start_i, start_addr_i, imem_data_i, stall_i, branch_taken_i, branch_target_i,
    input  imem_addr_o, imem_rd_o, instr_o, instr_valid_o, done_o, cycle_count_o, instr_count_o
  );

  modport slave (
    input  start_i, start_addr_i, imem_data_i, stall_i, branch_taken_i, branch_target_i,
    output imem_addr_o, imem_rd_o, instr_o, instr_valid_o, done_o, cycle_count_o, instr_count_o
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run controller for the lab3 CPU: accepts a start, walks FETCH/WAIT/EXEC per
// instruction against a synchronous instruction memory, stops on HALT.
module cpu_run_ctrl #(
  parameter int                 ADDR_W     = 8,
  parameter int                 INSTR_W    = 9,
  parameter logic [INSTR_W-1:0] HALT_INSTR = {INSTR_W{1'b1}},
  parameter int                 CNT_W      = 16
) (
  input logic           clock_i,
  input logic           reset_n_i,
  cpu_run_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, EXEC, DONE} state_t;

  state_t             state_reg;
  logic [ADDR_W-1:0]  pc_reg;
  logic [INSTR_W-1:0] instr_reg;
  logic               rd_reg;
  logic               valid_reg;
  logic               done_reg;
  logic [CNT_W-1:0]   cycle_cnt_reg;
  logic [CNT_W-1:0]   instr_cnt_reg;
  logic               running;

  assign running = (state_reg == FETCH) || (state_reg == WAIT) || (state_reg == EXEC);

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg     <= IDLE;
      pc_reg        <= '0;
      instr_reg     <= '0;
      rd_reg        <= 1'b0;
      valid_reg     <= 1'b0;
      done_reg      <= 1'b0;
      cycle_cnt_reg <= '0;
      instr_cnt_reg <= '0;
    end else begin
      if (running && cycle_cnt_reg != {CNT_W{1'b1}})
        cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);

      case (state_reg)
        IDLE, DONE: begin
          if (bus.start_i) begin
            pc_reg        <= bus.start_addr_i;
            instr_reg     <= '0;
            done_reg      <= 1'b0;
            cycle_cnt_reg <= '0;
            instr_cnt_reg <= '0;
            rd_reg        <= 1'b1;
            state_reg     <= FETCH;
          end
        end
        FETCH: begin
          rd_reg    <= 1'b0;
          state_reg <= WAIT;
        end
        WAIT: begin
          // valid is decided here so a HALT word is never presented as executable
          instr_reg <= bus.imem_data_i;
          valid_reg <= (bus.imem_data_i != HALT_INSTR);
          state_reg <= EXEC;
        end
        EXEC: begin
          if (instr_reg == HALT_INSTR) begin
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else if (!bus.stall_i) begin
            if (instr_cnt_reg != {CNT_W{1'b1}})
              instr_cnt_reg <= instr_cnt_reg + CNT_W'(1);
            pc_reg    <= bus.branch_taken_i ? bus.branch_target_i : pc_reg + ADDR_W'(1);
            valid_reg <= 1'b0;
            rd_reg    <= 1'b1;
            state_reg <= FETCH;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.imem_addr_o   = pc_reg;
  assign bus.imem_rd_o     = rd_reg;
  assign bus.instr_o       = instr_reg;
  assign bus.instr_valid_o = valid_reg;
  assign bus.done_o        = done_reg;
  assign bus.cycle_count_o = cycle_cnt_reg;
  assign bus.instr_count_o = instr_cnt_reg;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: program-level reference model (fetch trace, retire
// count, cycle cost) compared against a cycle driver acting as memory + datapath.
module tb_cpu_run_ctrl;
  localparam int         ADDR_W  = 8;
  localparam int         INSTR_W = 9;
  localparam int         CNT_W   = 16;
  localparam logic [8:0] HALT    = 9'h1FF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();

  cpu_run_ctrl #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .HALT_INSTR(HALT), .CNT_W(CNT_W)) dut (
    .clock_i  (clk),
    .reset_n_i(rst_n),
    .bus      (bus)
  );

  logic [8:0] mem [256];
  always @(posedge clk) if (bus.imem_rd_o) bus.imem_data_i <= mem[bus.imem_addr_o];

  int n_cmp = 0;
  int n_fail = 0;

  int         stall_plan [64];
  bit         br_plan    [64];
  logic [7:0] tgt_plan   [64];

  logic [7:0] exp_fetch[$];
  logic [8:0] exp_instr[$];
  int         exp_retired, exp_cycles, exp_valid;

  logic [7:0]  obs_fetch[$];
  logic [8:0]  obs_instr[$];
  int          obs_edges, obs_valid, obs_hold_err;
  logic        obs_done0;
  logic [15:0] obs_cyc0, obs_icnt0;
  bit          timed_out, aborted;

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) begin
      logic [8:0] v;
      v = 9'($urandom);
      if (v == HALT) v = 9'h0;
      mem[i] = v;
    end
  endtask

  task automatic clear_plans();
    for (int i = 0; i < 64; i++) begin
      stall_plan[i] = 0; br_plan[i] = 1'b0; tgt_plan[i] = 8'h0;
    end
  endtask

  // Program-level model: walk the program, each instruction costs 3 cycles plus its stalls.
  task automatic model_run(input logic [7:0] start);
    int pc, k, stalls;
    exp_fetch.delete(); exp_instr.delete();
    pc = start; k = 0; stalls = 0;
    for (int step = 0; step < 300; step++) begin
      exp_fetch.push_back(8'(pc));
      if (mem[pc] == HALT) break;
      exp_instr.push_back(mem[pc]);
      stalls += stall_plan[k % 64];
      pc = br_plan[k % 64] ? int'(tgt_plan[k % 64]) : (pc + 1) % 256;
      k++;
    end
    exp_retired = k;
    exp_cycles  = 3 * (k + 1) + stalls;
    exp_valid   = k + stalls;
  endtask

  function automatic int fetch_diff();
    int n = (obs_fetch.size() < exp_fetch.size()) ? obs_fetch.size() : exp_fetch.size();
    for (int i = 0; i < n; i++) if (obs_fetch[i] !== exp_fetch[i]) return i;
    return (obs_fetch.size() == exp_fetch.size()) ? -1 : n;
  endfunction

  function automatic int instr_diff();
    int n = (obs_instr.size() < exp_instr.size()) ? obs_instr.size() : exp_instr.size();
    for (int i = 0; i < n; i++) if (obs_instr[i] !== exp_instr[i]) return i;
    return (obs_instr.size() == exp_instr.size()) ? -1 : n;
  endfunction

  // Drives one run and records what the DUT did; abort_at >= 0 asserts reset
  // while instruction number abort_at is in EXEC.
  task automatic run_prog(input logic [7:0] start, input bit noisy, input int abort_at);
    int k, rem;
    bit loaded;
    logic [8:0] held;
    obs_fetch.delete(); obs_instr.delete();
    obs_edges = 0; obs_valid = 0; obs_hold_err = 0;
    timed_out = 1'b0; aborted = 1'b0;
    k = 0; rem = 0; loaded = 1'b0; held = '0;
    @(negedge clk);
    bus.start_i = 1'b1; bus.start_addr_i = start;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0; bus.start_addr_i = 8'($urandom);
    obs_done0 = bus.done_o; obs_cyc0 = bus.cycle_count_o; obs_icnt0 = bus.instr_count_o;
    forever begin
      if (bus.done_o) break;
      if (obs_edges >= 2000) begin timed_out = 1'b1; break; end
      if (bus.imem_rd_o) obs_fetch.push_back(bus.imem_addr_o);
      bus.branch_taken_i  = 1'($urandom);
      bus.branch_target_i = 8'($urandom);
      bus.stall_i         = 1'($urandom);
      if (noisy) begin bus.start_i = 1'($urandom); bus.start_addr_i = 8'($urandom); end
      if (bus.instr_valid_o) begin
        obs_valid++;
        if (!loaded) begin loaded = 1'b1; rem = stall_plan[k % 64]; held = bus.instr_o; end
        else if (bus.instr_o !== held) obs_hold_err++;
        if (abort_at >= 0 && k == abort_at) begin #2 rst_n = 1'b0; aborted = 1'b1; break; end
        if (rem > 0) begin
          bus.stall_i = 1'b1; rem--;
        end else begin
          bus.stall_i = 1'b0;
          bus.branch_taken_i  = br_plan[k % 64];
          bus.branch_target_i = tgt_plan[k % 64];
          obs_instr.push_back(bus.instr_o);
          k++; loaded = 1'b0;
        end
      end
      @(negedge clk);
      obs_edges++;
    end
    bus.start_i = 1'b0; bus.stall_i = 1'b0;
    $display("run start=%0d fetched=%0d retired=%0d edges=%0d cycles=%0d instrs=%0d",
             start, obs_fetch.size(), obs_instr.size(), obs_edges,
             bus.cycle_count_o, bus.instr_count_o);
  endtask

  task automatic test_reset();
    bus.start_i = 1'b0; bus.start_addr_i = 8'h0; bus.stall_i = 1'b0;
    bus.branch_taken_i = 1'b0; bus.branch_target_i = 8'h0;
    fill_mem();
    repeat (2) @(negedge clk);
    n_cmp++; if ({bus.imem_addr_o, bus.imem_rd_o, bus.instr_o, bus.instr_valid_o, bus.done_o} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: addr=%0d rd=%b instr=%h valid=%b done=%b, want all 0",
                         bus.imem_addr_o, bus.imem_rd_o, bus.instr_o, bus.instr_valid_o, bus.done_o); end
    n_cmp++; if (bus.cycle_count_o !== 16'd0 || bus.instr_count_o !== 16'd0) begin
      n_fail++; $display("FAIL reset_counters: cyc=%0d instr=%0d, want 0", bus.cycle_count_o, bus.instr_count_o); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.imem_rd_o !== 1'b0 || bus.cycle_count_o !== 16'd0) begin
      n_fail++; $display("FAIL idle_quiet: rd=%b cyc=%0d, want 0 0", bus.imem_rd_o, bus.cycle_count_o); end
  endtask

  task automatic test_sequential();
    fill_mem(); clear_plans(); mem[3] = HALT;
    model_run(8'd0); run_prog(8'd0, 1'b0, -1);
    n_cmp++; if (timed_out) begin n_fail++; $display("FAIL seq_timeout: done never rose"); end
    n_cmp++; if (fetch_diff() != -1) begin
      n_fail++; $display("FAIL seq_fetch: %0d addrs, diff at %0d, want %0d addrs", obs_fetch.size(), fetch_diff(), exp_fetch.size()); end
    n_cmp++; if (obs_edges !== 12) begin n_fail++; $display("FAIL seq_done_latency: %0d edges, want 12", obs_edges); end
    n_cmp++; if (bus.instr_count_o !== 16'd3) begin n_fail++; $display("FAIL seq_icount: %0d, want 3", bus.instr_count_o); end
    n_cmp++; if (bus.cycle_count_o !== 16'(exp_cycles)) begin
      n_fail++; $display("FAIL seq_ccount: %0d, want %0d", bus.cycle_count_o, exp_cycles); end
  endtask

  task automatic test_restart();
    fill_mem(); clear_plans(); mem[95] = HALT;
    model_run(8'd93); run_prog(8'd93, 1'b0, -1);
    n_cmp++; if (obs_done0 !== 1'b0) begin n_fail++; $display("FAIL restart_done_fall: done=%b after accept, want 0", obs_done0); end
    n_cmp++; if (obs_cyc0 !== 16'd0 || obs_icnt0 !== 16'd0) begin
      n_fail++; $display("FAIL restart_clear: cyc=%0d instr=%0d after accept, want 0 0", obs_cyc0, obs_icnt0); end
    n_cmp++; if (fetch_diff() != -1) begin
      n_fail++; $display("FAIL restart_fetch: first=%0d n=%0d diff at %0d, want first 93", obs_fetch.size() ? obs_fetch[0] : 8'h0, obs_fetch.size(), fetch_diff()); end
    n_cmp++; if (bus.instr_count_o !== 16'(exp_retired) || bus.cycle_count_o !== 16'(exp_cycles) || !bus.done_o) begin
      n_fail++; $display("FAIL restart_counts: instr=%0d cyc=%0d done=%b, want %0d %0d 1",
                         bus.instr_count_o, bus.cycle_count_o, bus.done_o, exp_retired, exp_cycles); end
  endtask

  task automatic test_branch();
    fill_mem(); clear_plans(); mem[200] = HALT; br_plan[0] = 1'b1; tgt_plan[0] = 8'd200;
    model_run(8'd138); run_prog(8'd138, 1'b0, -1);
    n_cmp++; if (fetch_diff() != -1) begin
      n_fail++; $display("FAIL branch_fetch: n=%0d diff at %0d second=%0d, want 138,200",
                         obs_fetch.size(), fetch_diff(), obs_fetch.size() > 1 ? obs_fetch[1] : 8'h0); end
    n_cmp++; if (bus.instr_count_o !== 16'd1) begin n_fail++; $display("FAIL branch_icount: %0d, want 1", bus.instr_count_o); end
  endtask

  task automatic test_stall();
    fill_mem(); clear_plans(); mem[12] = HALT; stall_plan[0] = 4;
    model_run(8'd10); run_prog(8'd10, 1'b0, -1);
    n_cmp++; if (fetch_diff() != -1) begin n_fail++; $display("FAIL stall_fetch: diff at %0d", fetch_diff()); end
    n_cmp++; if (obs_valid !== exp_valid || obs_hold_err !== 0) begin
      n_fail++; $display("FAIL stall_hold: valid cycles=%0d hold errs=%0d, want %0d 0", obs_valid, obs_hold_err, exp_valid); end
    n_cmp++; if (bus.cycle_count_o !== 16'd13) begin n_fail++; $display("FAIL stall_ccount: %0d, want 13", bus.cycle_count_o); end
  endtask

  task automatic test_wrap();
    fill_mem(); clear_plans(); mem[0] = HALT;
    model_run(8'd255); run_prog(8'd255, 1'b0, -1);
    n_cmp++; if (fetch_diff() != -1) begin n_fail++; $display("FAIL wrap_fetch: n=%0d diff at %0d, want 255,0", obs_fetch.size(), fetch_diff()); end
    n_cmp++; if (bus.instr_count_o !== 16'd1 || bus.done_o !== 1'b1) begin
      n_fail++; $display("FAIL wrap_done: instr=%0d done=%b, want 1 1", bus.instr_count_o, bus.done_o); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [7:0] halt_addr, start;
      int n;
      fill_mem(); clear_plans();
      halt_addr = 8'($urandom); mem[halt_addr] = HALT;
      n = $urandom_range(1, 20);
      for (int k = 0; k <= n; k++) begin
        stall_plan[k] = $urandom_range(0, 3);
        br_plan[k] = ($urandom % 3 == 0);
        do tgt_plan[k] = 8'($urandom); while (tgt_plan[k] == halt_addr);
      end
      br_plan[n] = 1'b1; tgt_plan[n] = halt_addr;
      start = 8'($urandom);
      model_run(start); run_prog(start, it[0], -1);
      n_cmp++; if (timed_out || fetch_diff() != -1) begin
        n_fail++; $display("FAIL rand%0d_fetch: timeout=%b n=%0d diff at %0d, want n=%0d", it, timed_out, obs_fetch.size(), fetch_diff(), exp_fetch.size()); end
      n_cmp++; if (instr_diff() != -1) begin n_fail++; $display("FAIL rand%0d_instr: diff at %0d", it, instr_diff()); end
      n_cmp++; if (bus.instr_count_o !== 16'(exp_retired) || bus.cycle_count_o !== 16'(exp_cycles) || obs_edges !== exp_cycles) begin
        n_fail++; $display("FAIL rand%0d_counts: instr=%0d cyc=%0d edges=%0d, want %0d %0d %0d",
                           it, bus.instr_count_o, bus.cycle_count_o, obs_edges, exp_retired, exp_cycles, exp_cycles); end
      n_cmp++; if (obs_valid !== exp_valid || obs_hold_err !== 0) begin
        n_fail++; $display("FAIL rand%0d_valid: valid=%0d holderr=%0d, want %0d 0", it, obs_valid, obs_hold_err, exp_valid); end
    end
  endtask

  task automatic test_reset_mid_exec();
    int d;
    fill_mem(); clear_plans(); mem[5] = HALT;
    model_run(8'd0); run_prog(8'd0, 1'b1, 2);
    #1;
    n_cmp++; if (!aborted) begin n_fail++; $display("FAIL abort_reached: aborted=%b, want 1", aborted); end
    n_cmp++; if ({bus.imem_addr_o, bus.imem_rd_o, bus.instr_o, bus.instr_valid_o, bus.done_o,
                  bus.cycle_count_o, bus.instr_count_o} !== '0) begin
      n_fail++; $display("FAIL abort_outputs: addr=%0d rd=%b instr=%h valid=%b done=%b cyc=%0d icnt=%0d, want all 0",
                         bus.imem_addr_o, bus.imem_rd_o, bus.instr_o, bus.instr_valid_o, bus.done_o,
                         bus.cycle_count_o, bus.instr_count_o); end
    d = -1;
    for (int i = 0; i < obs_fetch.size(); i++) if (d < 0 && obs_fetch[i] !== exp_fetch[i]) d = i;
    n_cmp++; if (obs_fetch.size() != 3 || d != -1) begin
      n_fail++; $display("FAIL abort_prefix: fetched %0d diff at %0d, want 3 matching 0,1,2", obs_fetch.size(), d); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.imem_rd_o !== 1'b0 || bus.cycle_count_o !== 16'd0) begin
      n_fail++; $display("FAIL abort_idle: rd=%b cyc=%0d, want 0 0", bus.imem_rd_o, bus.cycle_count_o); end
    model_run(8'd0); run_prog(8'd0, 1'b0, -1);
    n_cmp++; if (fetch_diff() != -1 || bus.instr_count_o !== 16'd5 || bus.cycle_count_o !== 16'(exp_cycles)) begin
      n_fail++; $display("FAIL abort_rerun: diff at %0d instr=%0d cyc=%0d, want -1 5 %0d",
                         fetch_diff(), bus.instr_count_o, bus.cycle_count_o, exp_cycles); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_restart();
    test_branch();
    test_stall();
    test_wrap();
    test_random();
    test_reset_mid_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
